mux_4_16_scanner: RTL and testbench

Sequential round-robin scanner that drives the select inputs of the 4:1 16-bit mux (`mux_4_16`) and captures its output. It visits requesting channels in rotation, holds the select lines stable for a configurable settle time, registers the mux output `y`, and hands each sample downstream over a valid/ready handshake tagged with its channel number. It sits directly around the mux: its selects feed the mux, and it consumes the mux output.

---
 rtl/mux_4_16_scanner_if.sv | 26 ++
 rtl/mux_4_16_scanner.sv | 109 ++++++++++
 tb/tb_mux_4_16_scanner.sv | 341 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mux_4_16_scanner_if.sv
// Bundle between the round-robin scanner, the 4:1 mux it steers and the downstream sample consumer.
// The master side is the scanner; the slave side is whoever drives req/en/y/out_ready.
interface mux_4_16_scanner_if #(
    parameter int WIDTH = 16
);
    logic             en;
    logic [3:0]       req;
    logic [WIDTH-1:0] y;
    logic             s0;
    logic             s1;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       out_ch;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    modport master (
        input  en, req, y, out_ready,
        output s0, s1, out_data, out_ch, out_valid, busy
    );

    modport slave (
        output en, req, y, out_ready,
        input  s0, s1, out_data, out_ch, out_valid, busy
    );
endinterface

// File: rtl/mux_4_16_scanner.sv
// Round-robin scanner: steers the mux selects onto a requesting channel, waits SETTLE cycles,
// captures y and offers it downstream with a valid/ready handshake tagged by channel number.
module mux_4_16_scanner #(
    parameter int WIDTH  = 16,
    parameter int SETTLE = 1
) (
    input logic                clk,
    input logic                rst_n,
    mux_4_16_scanner_if.master bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} state_e;

    localparam logic [3:0] CNT_LOAD = 4'(SETTLE - 1);

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       outCh_q, outCh_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] outData_q, outData_d;
    logic             outValid_q, outValid_d;
    logic             grantValid;
    logic [1:0]       grantCh;
    logic [1:0]       cand;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 2'd0;
            sel_q      <= 2'd0;
            outCh_q    <= 2'd0;
            cnt_q      <= 4'd0;
            outData_q  <= '0;
            outValid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            sel_q      <= sel_d;
            outCh_q    <= outCh_d;
            cnt_q      <= cnt_d;
            outData_q  <= outData_d;
            outValid_q <= outValid_d;
        end
    end

    // Walking the offset downward lets the requester closest to ptr overwrite the others.
    always_comb begin
        grantValid = 1'b0;
        grantCh    = ptr_q;
        cand       = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (bus.req[cand]) begin
                grantValid = 1'b1;
                grantCh    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (bus.en && grantValid) state_d = ST_SETTLE;
            ST_SETTLE: if (cnt_q == 4'd0) state_d = ST_HOLD;
            ST_HOLD:   if (outValid_q && bus.out_ready) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        ptr_d      = ptr_q;
        sel_d      = sel_q;
        outCh_d    = outCh_q;
        cnt_d      = cnt_q;
        outData_d  = outData_q;
        outValid_d = outValid_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.en && grantValid) begin
                    sel_d   = grantCh;
                    outCh_d = grantCh;
                    cnt_d   = CNT_LOAD;
                end
            end
            ST_SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    outData_d  = bus.y;
                    outValid_d = 1'b1;
                end
            end
            ST_HOLD: begin
                if (outValid_q && bus.out_ready) begin
                    outValid_d = 1'b0;
                    ptr_d      = outCh_q + 2'd1;
                end
            end
            default: ;
        endcase
    end

    assign bus.s0        = sel_q[1];
    assign bus.s1        = sel_q[0];
    assign bus.out_data  = outData_q;
    assign bus.out_ch    = outCh_q;
    assign bus.out_valid = outValid_q;
    assign bus.busy      = (state_q != ST_IDLE);
endmodule

// File: tb/tb_mux_4_16_scanner.sv
// Bench for the scanner: two instances (SETTLE=1 and SETTLE=3), each wrapped around a behavioural 4:1 mux.
// Directed scenarios plus a randomized run scored against a channel-rotation reference model.
module tb_mux_4_16_scanner;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;

    logic [15:0] dA [4];
    logic [15:0] dB [4];

    mux_4_16_scanner_if #(.WIDTH(16)) busA ();
    mux_4_16_scanner_if #(.WIDTH(16)) busB ();

    assign busA.y = dA[{busA.s0, busA.s1}];
    assign busB.y = dB[{busB.s0, busB.s1}];

    mux_4_16_scanner #(.WIDTH(16), .SETTLE(1)) dutA (.clk(clk), .rst_n(rst_n), .bus(busA.master));
    mux_4_16_scanner #(.WIDTH(16), .SETTLE(3)) dutB (.clk(clk), .rst_n(rst_n), .bus(busB.master));

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // The first requester met when walking upward from p, wrapping after channel 3.
    function automatic logic [1:0] nextCh(input logic [1:0] p, input logic [3:0] r);
        for (int k = 0; k < 4; k++) begin
            if (r[(int'(p) + k) % 4]) return 2'((int'(p) + k) % 4);
        end
        return p;
    endfunction

    task automatic waitValidA(input int maxEdges, output int edges, output bit ok);
        ok = 1'b0;
        edges = 0;
        while (!ok && edges < maxEdges) begin
            @(posedge clk);
            #1;
            edges++;
            if (busA.out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busA.out_valid, busA.out_ch, busA.s0, busA.s1, busA.busy, busA.out_data} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_A: got %h want 0", {busA.out_valid, busA.out_ch, busA.s0, busA.s1, busA.busy, busA.out_data});
        end
        checks++;
        if ({busB.out_valid, busB.out_ch, busB.s0, busB.s1, busB.busy, busB.out_data} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL reset_B: got %h want 0", {busB.out_valid, busB.out_ch, busB.s0, busB.s1, busB.busy, busB.out_data});
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_rotation(input logic [3:0] reqPat, input int n, input logic [1:0] expCh [5], input string tag);
        int  edges;
        bit  ok;
        int  lastCyc;
        busA.req = reqPat;
        busA.en = 1'b1;
        busA.out_ready = 1'b1;
        lastCyc = 0;
        for (int i = 0; i < n; i++) begin
            waitValidA(12, edges, ok);
            checks++;
            if (!ok) begin
                errors++;
                $display("[TB] FAIL %s_timeout: sample %0d got no valid want valid", tag, i);
                return;
            end
            checks++;
            if ({busA.out_ch, busA.out_data} !== {expCh[i], dA[expCh[i]]}) begin
                errors++;
                $display("[TB] FAIL %s_sample%0d: got (%0d,%0d) want (%0d,%0d)", tag, i,
                         busA.out_ch, busA.out_data, expCh[i], dA[expCh[i]]);
            end
            checks++;
            if ({busA.s0, busA.s1} !== expCh[i]) begin
                errors++;
                $display("[TB] FAIL %s_sel%0d: got %0d want %0d", tag, i, {busA.s0, busA.s1}, expCh[i]);
            end
            if (i > 0) begin
                checks++;
                if (cyc - lastCyc !== 3) begin
                    errors++;
                    $display("[TB] FAIL %s_period%0d: got %0d want 3", tag, i, cyc - lastCyc);
                end
            end
            lastCyc = cyc;
            @(posedge clk);
            #1;
            checks++;
            if (busA.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL %s_pulse%0d: got %b want 0", tag, i, busA.out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        int edges;
        bit ok;
        busA.req = 4'b0001;
        busA.out_ready = 1'b0;
        waitValidA(12, edges, ok);
        checks++;
        if (!ok || {busA.out_ch, busA.out_data} !== {2'd0, 16'd4}) begin
            errors++;
            $display("[TB] FAIL bp_first: got (%0d,%0d) valid=%b want (0,4)", busA.out_ch, busA.out_data, busA.out_valid);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busA.out_valid, busA.out_data, busA.s0, busA.s1} !== {1'b1, 16'd4, 2'b00}) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: got v=%b d=%0d sel=%0d want v=1 d=4 sel=0", i,
                         busA.out_valid, busA.out_data, {busA.s0, busA.s1});
            end
        end
        busA.req = 4'b1111;
        busA.out_ready = 1'b1;
        waitValidA(12, edges, ok);
        checks++;
        if (!ok || {busA.out_ch, busA.out_data} !== {2'd1, 16'd16}) begin
            errors++;
            $display("[TB] FAIL bp_next: got (%0d,%0d) want (1,16)", busA.out_ch, busA.out_data);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_enable_drop();
        int edges;
        bit ok;
        @(posedge clk);
        #1;
        checks++;
        if ({busA.busy, busA.s0, busA.s1, busA.out_valid} !== 4'b1100) begin
            errors++;
            $display("[TB] FAIL en_grant: got busy=%b sel=%0d v=%b want busy=1 sel=2 v=0",
                     busA.busy, {busA.s0, busA.s1}, busA.out_valid);
        end
        busA.en = 1'b0;
        waitValidA(12, edges, ok);
        checks++;
        if (!ok || {busA.out_ch, busA.out_data} !== {2'd2, 16'd32}) begin
            errors++;
            $display("[TB] FAIL en_deliver: got (%0d,%0d) want (2,32)", busA.out_ch, busA.out_data);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if ({busA.busy, busA.out_valid} !== 2'b00) begin
                errors++;
                $display("[TB] FAIL en_quiet%0d: got busy=%b v=%b want 0 0", i, busA.busy, busA.out_valid);
            end
        end
        busA.out_ready = 1'b0;
        busA.en = 1'b1;
        waitValidA(12, edges, ok);
        checks++;
        if (!ok || {busA.out_ch, busA.out_data} !== {2'd3, 16'd87}) begin
            errors++;
            $display("[TB] FAIL en_resume: got (%0d,%0d) want (3,87)", busA.out_ch, busA.out_data);
        end
    endtask

    task automatic test_reset_mid_hold();
        int edges;
        bit ok;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busA.out_valid, busA.out_ch, busA.s0, busA.s1, busA.busy, busA.out_data} !== 22'd0) begin
            errors++;
            $display("[TB] FAIL rst_async: got %h want 0", {busA.out_valid, busA.out_ch, busA.s0, busA.s1, busA.busy, busA.out_data});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        busA.out_ready = 1'b1;
        busA.req = 4'b1111;
        waitValidA(12, edges, ok);
        checks++;
        if (!ok || edges !== 2 || {busA.out_ch, busA.out_data} !== {2'd0, 16'd4}) begin
            errors++;
            $display("[TB] FAIL rst_restart: got (%0d,%0d) after %0d edges want (0,4) after 2",
                     busA.out_ch, busA.out_data, edges);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [1:0] mPtr;
        logic [3:0] mReq;
        logic [1:0] expCh;
        bit         waiting;
        bit         r;
        int         idle;
        int         samples;
        mPtr = 2'd1;
        mReq = 4'b1111;
        waiting = 1'b0;
        idle = 0;
        samples = 0;
        for (int c = 0; c < 300; c++) begin
            @(posedge clk);
            #1;
            expCh = nextCh(mPtr, mReq);
            if (busA.out_valid === 1'b1) begin
                idle = 0;
                checks++;
                if ({busA.out_ch, busA.out_data, busA.s0, busA.s1} !== {expCh, dA[expCh], expCh}) begin
                    errors++;
                    $display("[TB] FAIL rand_sample: got ch=%0d d=%0d sel=%0d want ch=%0d d=%0d",
                             busA.out_ch, busA.out_data, {busA.s0, busA.s1}, expCh, dA[expCh]);
                end
            end else begin
                if (waiting) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rand_drop: got valid=0 want 1 while stalled");
                end
                idle++;
                if (idle > 4) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL rand_timeout: got %0d idle cycles want <=4", idle);
                    return;
                end
            end
            r = ($urandom_range(0, 3) != 0);
            busA.out_ready = r;
            waiting = 1'b0;
            if (busA.out_valid === 1'b1 && r) begin
                mPtr = expCh + 2'd1;
                mReq = 4'($urandom_range(1, 15));
                busA.req = mReq;
                for (int k = 0; k < 4; k++) dA[k] = 16'($urandom);
                samples++;
            end else if (busA.out_valid === 1'b1) begin
                waiting = 1'b1;
            end
        end
        checks++;
        if (samples < 20) begin
            errors++;
            $display("[TB] FAIL rand_count: got %0d samples want >=20", samples);
        end
        busA.en = 1'b0;
        busA.out_ready = 1'b1;
    endtask

    task automatic test_settle3();
        logic [15:0] expD;
        busB.req = 4'b0100;
        busB.en = 1'b1;
        busB.out_ready = 1'b1;
        for (int run = 0; run < 2; run++) begin
            expD = (run == 0) ? 16'd32 : 16'd99;
            @(posedge clk);
            #1;
            checks++;
            if ({busB.s0, busB.s1, busB.busy, busB.out_valid} !== 4'b1010) begin
                errors++;
                $display("[TB] FAIL s3_grant%0d: got sel=%0d busy=%b v=%b want sel=2 busy=1 v=0", run,
                         {busB.s0, busB.s1}, busB.busy, busB.out_valid);
            end
            if (run == 1) dB[2] = 16'd99;
            for (int j = 1; j < 3; j++) begin
                @(posedge clk);
                #1;
                checks++;
                if (busB.out_valid !== 1'b0) begin
                    errors++;
                    $display("[TB] FAIL s3_early%0d_%0d: got v=%b want 0", run, j, busB.out_valid);
                end
            end
            @(posedge clk);
            #1;
            checks++;
            if ({busB.out_valid, busB.out_ch, busB.out_data} !== {1'b1, 2'd2, expD}) begin
                errors++;
                $display("[TB] FAIL s3_sample%0d: got v=%b (%0d,%0d) want v=1 (2,%0d)", run,
                         busB.out_valid, busB.out_ch, busB.out_data, expD);
            end
            @(posedge clk);
            #1;
            checks++;
            if (busB.out_valid !== 1'b0) begin
                errors++;
                $display("[TB] FAIL s3_pulse%0d: got v=%b want 0", run, busB.out_valid);
            end
        end
        busB.en = 1'b0;
    endtask

    initial begin
        logic [1:0] seq1 [5];
        logic [1:0] seq2 [5];
        seq1 = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        seq2 = '{2'd1, 2'd3, 2'd1, 2'd0, 2'd0};
        dA = '{16'd4, 16'd16, 16'd32, 16'd87};
        dB = '{16'd4, 16'd16, 16'd32, 16'd87};
        busA.en = 1'b0;
        busA.req = 4'b0000;
        busA.out_ready = 1'b1;
        busB.en = 1'b0;
        busB.req = 4'b0000;
        busB.out_ready = 1'b1;
        $display("[TB] starting scanner bench");
        test_reset();
        test_rotation(4'b1111, 5, seq1, "rr_all");
        test_rotation(4'b1010, 3, seq2, "rr_odd");
        test_backpressure();
        test_enable_drop();
        test_reset_mid_hold();
        test_random();
        test_settle3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got no finish want finish before 500000");
        $fatal(1, "[TB] watchdog expired");
    end
endmodule
